// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receiver FSM states and default frame geometry
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync_2ff.sv
// rtl/uart_sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver; UART_RX_PARITY_EN adds a parity bit
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TCW-1:0] TICK_HALF = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 rx_s;
  logic                 tick_prev;
  logic                 tick;
  logic [TCW-1:0]       tick_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 at_half, at_last, stop_sample, par_bad;
  logic                 valid_d, frame_err_d, parity_err_d;

  uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // A tick held high for several clocks must count once.
  assign tick        = i_tick & ~tick_prev;
  assign at_half     = tick && (tick_cnt == TICK_HALF);
  assign at_last     = tick && (tick_cnt == TICK_LAST);
  assign stop_sample = (state == STOP) && at_last;

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  assign par_bad = parity_bit ^ (^shift) ^ PARITY_ODD[0];
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!rx_s) state_next = START;
      START:  if (at_half) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (at_last && bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: if (at_last) state_next = STOP;
      STOP:   if (at_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame error wins over parity error so only one strobe fires per frame.
  always_comb begin
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (stop_sample) begin
      frame_err_d  = ~rx_s;
      parity_err_d = rx_s & par_bad;
      valid_d      = rx_s & ~par_bad;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_prev    <= 1'b0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      tick_prev    <= i_tick;
      o_valid      <= valid_d;
      o_frame_err  <= frame_err_d;
      o_parity_err <= parity_err_d;
      case (state)
        IDLE: tick_cnt <= '0;
        START: begin
          bit_cnt <= '0;
          if (tick) tick_cnt <= at_half ? '0 : tick_cnt + 1'b1;
        end
        default: begin
          if (tick) tick_cnt <= at_last ? '0 : tick_cnt + 1'b1;
          if (state == DATA && at_last) begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          if (state == PARITY && at_last) parity_bit <= rx_s;
`endif
        end
      endcase
      if (stop_sample) o_data <= shift;
    end
  end

endmodule
